// File: rtl/cordic_iter_engine.sv
// Iterative CORDIC engine: one micro-rotation per clock, rotation and vectoring modes.
// Defining CORDIC_GAIN_COMP_EN adds a one-cycle COMP state that removes the CORDIC gain.
module cordic_iter_engine #(
    parameter int WIDTH = 32,
    parameter int ITER  = 16
) (
    input  logic             clk,
    input  logic             RST,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_mode,
    input  logic [WIDTH-1:0] in_x,
    input  logic [WIDTH-1:0] in_y,
    input  logic [WIDTH-1:0] in_z,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_x,
    output logic [WIDTH-1:0] out_y,
    output logic [WIDTH-1:0] out_z
);

    // Two guard bits absorb the CORDIC gain and the pre-rotation negation of -2^(WIDTH-1).
    localparam int  XW = WIDTH + 2;
    localparam int  IW = $clog2(WIDTH);
    localparam real PI = 3.14159265358979323846;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRE,
        S_ITER,
`ifdef CORDIC_GAIN_COMP_EN
        S_COMP,
`endif
        S_DONE
    } state_t;

    function automatic logic [WIDTH-1:0] atan_entry(input int k);
        real a;
        a = $atan(1.0 / (2.0 ** k)) * (2.0 ** WIDTH) / (2.0 * PI);
        return WIDTH'($rtoi(a + 0.5));
    endfunction

    function automatic logic [WIDTH-1:0] saturate(input logic signed [XW-1:0] v);
        if (v[XW-1:WIDTH-1] == '0 || v[XW-1:WIDTH-1] == '1)
            return v[WIDTH-1:0];
        else if (v[XW-1])
            return {1'b1, {(WIDTH-1){1'b0}}};
        else
            return {1'b0, {(WIDTH-1){1'b1}}};
    endfunction

`ifdef CORDIC_GAIN_COMP_EN
    // 1/2 + 1/8 - 1/64 - 1/512 approximates 1/1.64676.
    function automatic logic signed [XW-1:0] gain_comp(input logic signed [XW-1:0] v);
        return (v >>> 1) + (v >>> 3) - (v >>> 6) - (v >>> 9);
    endfunction
`endif

    logic [WIDTH-1:0] atan_tab [ITER];

    for (genvar g = 0; g < ITER; g++) begin : g_atan
        localparam logic [WIDTH-1:0] ANGLE = atan_entry(g);
        assign atan_tab[g] = ANGLE;
    end

    state_t                  state_q, state_d;
    logic [IW-1:0]           i_q;
    logic                    mode_q;
    logic signed [XW-1:0]    x_q, y_q;
    logic [WIDTH-1:0]        z_q;

    logic                    pre_flip, dir_pos;
    logic signed [XW-1:0]    pre_x, pre_y, x_sh, y_sh, x_nx, y_nx;
    logic [WIDTH-1:0]        pre_z, z_nx, angle;

    always_comb begin
        pre_flip = mode_q ? x_q[XW-1] : (z_q[WIDTH-1] ^ z_q[WIDTH-2]);
        pre_x    = pre_flip ? -x_q : x_q;
        pre_y    = pre_flip ? -y_q : y_q;
        // Adding pi to a binary angle only toggles its MSB, same as the rotation-mode fold.
        pre_z    = {z_q[WIDTH-1] ^ pre_flip, z_q[WIDTH-2:0]};

        dir_pos  = mode_q ? y_q[XW-1] : ~z_q[WIDTH-1];
        x_sh     = x_q >>> i_q;
        y_sh     = y_q >>> i_q;
        angle    = atan_tab[i_q];
        if (dir_pos) begin
            x_nx = x_q - y_sh;
            y_nx = y_q + x_sh;
            z_nx = z_q - angle;
        end else begin
            x_nx = x_q + y_sh;
            y_nx = y_q - x_sh;
            z_nx = z_q + angle;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge RST) begin
        if (RST) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // NOTE: state_d gets a default first so no path through the case infers a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (in_valid) state_d = S_PRE;
            S_PRE:  state_d = S_ITER;
            S_ITER: if (i_q == IW'(ITER - 1)) begin
`ifdef CORDIC_GAIN_COMP_EN
                state_d = S_COMP;
`else
                state_d = S_DONE;
`endif
            end
`ifdef CORDIC_GAIN_COMP_EN
            S_COMP: state_d = S_DONE;
`endif
            S_DONE: if (out_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            i_q    <= '0;
            mode_q <= 1'b0;
            x_q    <= '0;
            y_q    <= '0;
            z_q    <= '0;
        end else begin
            case (state_q)
                S_IDLE: if (in_valid) begin
                    mode_q <= in_mode;
                    x_q    <= {{2{in_x[WIDTH-1]}}, in_x};
                    y_q    <= {{2{in_y[WIDTH-1]}}, in_y};
                    z_q    <= in_z;
                    i_q    <= '0;
                end
                S_PRE: begin
                    x_q <= pre_x;
                    y_q <= pre_y;
                    z_q <= pre_z;
                    i_q <= '0;
                end
                S_ITER: begin
                    x_q <= x_nx;
                    y_q <= y_nx;
                    z_q <= z_nx;
                    i_q <= i_q + IW'(1);
                end
`ifdef CORDIC_GAIN_COMP_EN
                S_COMP: begin
                    x_q <= gain_comp(x_q);
                    y_q <= gain_comp(y_q);
                end
`endif
                default: ;
            endcase
        end
    end

    always_comb begin
        in_ready  = (state_q == S_IDLE) && !RST;
        out_valid = (state_q == S_DONE);
        out_x     = '0;
        out_y     = '0;
        out_z     = '0;
        if (out_valid) begin
            out_x = saturate(x_q);
            out_y = saturate(y_q);
            out_z = z_q;
        end
    end

endmodule

// File: tb/tb_cordic_iter_engine.sv
// Self-checking bench for cordic_iter_engine: arithmetic CORDIC model plus spec-level literals.
// Follows CORDIC_GAIN_COMP_EN the same way the design does.
module tb_cordic_iter_engine;

    localparam int W = 32;
    localparam int N = 16;
`ifdef CORDIC_GAIN_COMP_EN
    localparam int LAT = N + 3;
`else
    localparam int LAT = N + 2;
`endif

    typedef struct {
        logic [W-1:0] x, y, z;
        time          t_acc;
        bit           seen;
    } exp_t;

    typedef struct {
        bit           m;
        logic [W-1:0] x, y, z;
    } vec_t;

    logic         clk = 1'b0;
    logic         RST;
    logic         in_valid, in_ready, in_mode, out_valid, out_ready;
    logic [W-1:0] in_x, in_y, in_z, out_x, out_y, out_z;

    int           n_checks = 0;
    int           n_pass   = 0;
    int           n_hs     = 0;
    time          last_hs  = 0;
    logic [W-1:0] cap_x, cap_y, cap_z;
    logic [W-1:0] atan_a [N];
    exp_t         exp_q [$];

    vec_t vecs [8] = '{
        '{1'b0, 32'h3000_0000, 32'h1000_0000, 32'h6000_0000},
        '{1'b0, 32'hE000_0000, 32'h0800_0000, 32'hA000_0000},
        '{1'b0, 32'h1234_5678, 32'hF89A_BCDF, 32'hE000_0000},
        '{1'b0, 32'h8000_0000, 32'h7FFF_FFFF, 32'h4000_0000},
        '{1'b1, 32'h2000_0000, 32'hD000_0000, 32'h1000_0000},
        '{1'b1, 32'hC000_0000, 32'h2000_0000, 32'h0000_0000},
        '{1'b1, 32'h8000_0000, 32'h8000_0000, 32'h7000_0000},
        '{1'b1, 32'h0000_0000, 32'h0000_0000, 32'h1234_0000}
    };

    always #5 clk = ~clk;

    cordic_iter_engine #(.WIDTH(W), .ITER(N)) dut (
        .clk       (clk),
        .RST       (RST),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_mode   (in_mode),
        .in_x      (in_x),
        .in_y      (in_y),
        .in_z      (in_z),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_x     (out_x),
        .out_y     (out_y),
        .out_z     (out_z)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: actual 0x%0h, required 0x%0h", name, act, req);
    endtask

    task automatic check_near(input string name, input longint act, input longint req, input longint tol);
        longint diff;
        n_checks++;
        diff = act - req;
        if (diff < 0) diff = -diff;
        if (diff <= tol) n_pass++;
        else $display("FAIL %s: actual %0d, required %0d +- %0d", name, act, req, tol);
    endtask

    function automatic logic [W-1:0] sat(input longint v);
        if (v > 64'sd2147483647)       return 32'h7FFF_FFFF;
        else if (v < -64'sd2147483648) return 32'h8000_0000;
        else                           return v[W-1:0];
    endfunction

    // Straight-line CORDIC on 64-bit integers: quadrant fold, N micro-rotations, optional gain fix.
    function automatic exp_t model(input bit mode, input logic [W-1:0] x0, y0, z0);
        longint       x, y, t;
        logic [W-1:0] z;
        bit           d;
        exp_t         e;
        x = longint'(signed'(x0));
        y = longint'(signed'(y0));
        z = z0;
        if (!mode) begin
            if (z[W-1] != z[W-2]) begin
                x = -x; y = -y; z[W-1] = ~z[W-1];
            end
        end else if (x < 0) begin
            x = -x; y = -y; z = z + 32'h8000_0000;
        end
        for (int i = 0; i < N; i++) begin
            d = mode ? (y < 0) : !z[W-1];
            if (d) begin
                t = x - (y >>> i); y = y + (x >>> i); x = t; z = z - atan_a[i];
            end else begin
                t = x + (y >>> i); y = y - (x >>> i); x = t; z = z + atan_a[i];
            end
        end
`ifdef CORDIC_GAIN_COMP_EN
        x = (x >>> 1) + (x >>> 3) - (x >>> 6) - (x >>> 9);
        y = (y >>> 1) + (y >>> 3) - (y >>> 6) - (y >>> 9);
`endif
        e.x = sat(x);
        e.y = sat(y);
        e.z = z;
        e.t_acc = 0;
        e.seen = 1'b0;
        return e;
    endfunction

    // Values expected near zero may keep the residual of the last micro-rotation:
    // an angle of up to A[N-1] and a y of up to |x| * 2^-(N-1).
    task automatic check_result(input string tag, input logic [W-1:0] rx, ry, rz,
                                input longint ex, input longint ey, input longint ez,
                                input longint tol_x);
        longint ytol, ztol;
        ytol = (ex < 0 ? -ex : ex) / (64'sd1 << (N - 1)) + 64;
        ztol = longint'(atan_a[N-1]) + 64;
        check_near({tag, " x"}, longint'(signed'(rx)), ex, tol_x);
        check_near({tag, " y"}, longint'(signed'(ry)), ey, (ey == 0) ? ytol : tol_x);
        check_near({tag, " z"}, longint'(signed'(rz - W'(ez))), 0, ztol);
    endtask

    // Single compare process: every cycle out_valid is high the outputs must match the model.
    always @(negedge clk) begin
        if (!RST && out_valid) begin
            if (exp_q.size() == 0) begin
                check("spurious out_valid", out_valid, 1'b0);
            end else begin
                check("out_x", out_x, exp_q[0].x);
                check("out_y", out_y, exp_q[0].y);
                check("out_z", out_z, exp_q[0].z);
                check("in_ready low in DONE", in_ready, 1'b0);
                if (!exp_q[0].seen) begin
                    exp_q[0].seen = 1'b1;
                    // Edges counted with the accept edge as the first.
                    check("latency edges", 64'(int'(($time - exp_q[0].t_acc - 5) / 10) + 1), LAT);
                    cap_x = out_x;
                    cap_y = out_y;
                    cap_z = out_z;
                end
                if (out_ready) begin
                    void'(exp_q.pop_front());
                    n_hs++;
                    last_hs = $time + 5;
                end
            end
        end
    end

    task automatic send(input bit mode, input logic [W-1:0] x, y, z,
                        input bit hold, input bit b2b, output time t_acc);
        exp_t e;
        int   k;
        in_mode  = mode;
        in_x     = x;
        in_y     = y;
        in_z     = z;
        in_valid = 1'b1;
        k = 0;
        while (!in_ready && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (!in_ready) begin
            check("accept timeout in_ready", in_ready, 1'b1);
            in_valid = 1'b0;
            t_acc = 0;
            return;
        end
        @(posedge clk);
        t_acc   = $time;
        e       = model(mode, x, y, z);
        e.t_acc = t_acc;
        exp_q.push_back(e);
        if (b2b) check("b2b accept one edge after handshake", t_acc - last_hs, 64'd10);
        #1;
        in_valid = hold;
        in_mode  = ~mode;
        in_x     = $urandom;
        in_y     = $urandom;
        in_z     = $urandom;
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 300) begin
            @(negedge clk);
            k++;
        end
        check("result drained", exp_q.size(), 0);
        exp_q.delete();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        time          t_acc, t_rel;
        exp_t         m;
        logic [W-1:0] s_x, s_y, s_z;
        int           k;

        for (int i = 0; i < N; i++)
            atan_a[i] = W'($rtoi($atan(1.0 / (2.0 ** i)) * (2.0 ** W) / (2.0 * 3.141592653589793) + 0.5));

        RST = 1'b1; in_valid = 1'b0; in_mode = 1'b0;
        in_x = '0; in_y = '0; in_z = '0; out_ready = 1'b1;
        #1;
        check("reset in_ready", in_ready, 1'b0);
        check("reset out_valid", out_valid, 1'b0);
        check("reset out_x", out_x, 0);
        check("reset out_y", out_y, 0);
        check("reset out_z", out_z, 0);
        repeat (3) @(negedge clk);
        RST = 1'b0;
        #1;
        check("in_ready after reset", in_ready, 1'b1);
        @(posedge clk);
        #1;

        // Pin the model to hand-derived values: A[0] is exactly 2^(W-3) for pi/4.
        check("model A[0]", atan_a[0], 32'h2000_0000);
`ifdef CORDIC_GAIN_COMP_EN
        m = model(1'b0, 32'h4000_0000, 32'h0, 32'h2000_0000);
        check_result("model rot45", m.x, m.y, m.z, 759300000, 759300000, 0, 759300);
        m = model(1'b1, 32'hF000_0000, 32'h0, 32'h0);
        check_result("model vec", m.x, m.y, m.z, 268435456, 0, 64'h8000_0000, 268435);
`else
        m = model(1'b0, 32'h1000_0000, 32'h0, 32'h0);
        check_result("model rot0", m.x, m.y, m.z, 442050000, 0, 0, 442050);
        m = model(1'b0, 32'h7FFF_FFFF, 32'h0, 32'h0);
        check("model saturation", m.x, 32'h7FFF_FFFF);
        m = model(1'b0, 32'h4000_0000, 32'h0, 32'h2000_0000);
        check_result("model rot45", m.x, m.y, m.z, 1250303000, 1250303000, 0, 1250303);
`endif

        // Spec vectors through the DUT, checked against literals as well as the model.
`ifdef CORDIC_GAIN_COMP_EN
        send(1'b0, 32'h4000_0000, 32'h0, 32'h2000_0000, 1'b0, 1'b0, t_acc);
        wait_idle();
        check_result("dut rot45", cap_x, cap_y, cap_z, 759300000, 759300000, 0, 759300);
        send(1'b1, 32'hF000_0000, 32'h0, 32'h0, 1'b0, 1'b0, t_acc);
        wait_idle();
        check_result("dut vec", cap_x, cap_y, cap_z, 268435456, 0, 64'h8000_0000, 268435);
`else
        send(1'b0, 32'h1000_0000, 32'h0, 32'h0, 1'b0, 1'b0, t_acc);
        wait_idle();
        check_result("dut rot0", cap_x, cap_y, cap_z, 442050000, 0, 0, 442050);
        send(1'b0, 32'h7FFF_FFFF, 32'h0, 32'h0, 1'b0, 1'b0, t_acc);
        wait_idle();
        check("dut saturation", cap_x, 32'h7FFF_FFFF);
        send(1'b1, 32'hF000_0000, 32'h0, 32'h0, 1'b0, 1'b0, t_acc);
        wait_idle();
        check_result("dut vec", cap_x, cap_y, cap_z, 442050000, 0, 64'h8000_0000, 442050);
`endif

        foreach (vecs[i]) begin
            send(vecs[i].m, vecs[i].x, vecs[i].y, vecs[i].z, 1'b0, 1'b0, t_acc);
            wait_idle();
        end

        // Backpressure: result must hold for ten cycles, then release in one edge.
        out_ready = 1'b0;
        send(1'b0, 32'h2345_6789, 32'hF000_1234, 32'h5000_0000, 1'b0, 1'b0, t_acc);
        k = 0;
        while (!out_valid && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("backpressure out_valid", out_valid, 1'b1);
        s_x = out_x; s_y = out_y; s_z = out_z;
        repeat (10) begin
            @(negedge clk);
            check("hold out_valid", out_valid, 1'b1);
            check("hold out_x", out_x, s_x);
            check("hold out_y", out_y, s_y);
            check("hold out_z", out_z, s_z);
            check("hold in_ready", in_ready, 1'b0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("release out_valid", out_valid, 1'b0);
        check("release in_ready", in_ready, 1'b1);
        wait_idle();

        // Reset during ITER with the counter at 5: everything clears, no result emerges.
        send(1'b1, 32'h3000_0000, 32'h1000_0000, 32'h0, 1'b0, 1'b0, t_acc);
        repeat (6) @(posedge clk);
        #2;
        RST = 1'b1;
        #1;
        exp_q.delete();
        check("abort out_valid", out_valid, 1'b0);
        check("abort out_x", out_x, 0);
        check("abort out_y", out_y, 0);
        check("abort out_z", out_z, 0);
        check("abort in_ready", in_ready, 1'b0);
        @(negedge clk);
        @(negedge clk);
        RST = 1'b0;
        t_rel = $time;
        #1;
        check("in_ready after abort", in_ready, 1'b1);
        send(1'b0, 32'h1000_0000, 32'h0, 32'h0, 1'b0, 1'b0, t_acc);
        check("first edge accept after reset", t_acc - t_rel, 64'd5);
        wait_idle();

        // Back-to-back with in_valid held high.
        n_hs = 0;
        send(1'b0, 32'h0800_0000, 32'h0400_0000, 32'h9000_0000, 1'b1, 1'b0, t_acc);
        send(1'b1, 32'hF800_0000, 32'h0C00_0000, 32'h0000_1000, 1'b1, 1'b1, t_acc);
        send(1'b0, 32'h7000_0000, 32'h8800_0000, 32'hC000_0000, 1'b0, 1'b1, t_acc);
        wait_idle();
        check("b2b handshakes", n_hs, 3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
